// File: rtl/dma_mem_responder.sv
// dma_mem_responder: single-port byte memory model that answers the DMA
// engine's memory-side read/write requests.
//   - Reads: one-cycle mem_read pulse, data returned READ_LAT edges later
//     with a one-cycle mem_ready pulse; busy while a read is outstanding.
//   - Writes: one-cycle mem_write, completed at the sampling edge.
//   - Backdoor: dbg_we/dbg_addr/dbg_wdata write port, dbg_rdata comb read.
//   - Status: rd_cnt, wr_cnt (wrap mod 2^16), sticky ovr_err, range_err.
// Optional macro DMA_MEM_WPROT_EN adds wp_lo/wp_hi (inclusive protected
// bus-write window, empty when wp_lo > wp_hi) and sticky wp_err.
// Ports: clk, rst (async, active-high), mem_addr, mem_read, mem_write,
// mem_wdata, mem_rdata, mem_ready, busy, dbg_we, dbg_addr, dbg_wdata,
// dbg_rdata, rd_cnt, wr_cnt, ovr_err, [wp_lo, wp_hi, wp_err], range_err.
module dma_mem_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              busy,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
  output logic              ovr_err,
`ifdef DMA_MEM_WPROT_EN
  input  logic [ADDR_W-1:0] wp_lo,
  input  logic [ADDR_W-1:0] wp_hi,
  output logic              wp_err,
`endif
  output logic              range_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  // Array covers the whole address space, so no address can be out of range.
  localparam bit FULL = (64'(DEPTH) >= (64'(1) << ADDR_W));

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_array [DEPTH];

  state_t            state;
  logic [CNT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ok;
  logic              bus_in_range;
  logic              dbg_in_range;
  logic              bus_wr_ok;

  // Address range decode for bus and backdoor ports.
  generate
    if (FULL) begin : g_full
      assign bus_in_range = 1'b1;
      assign dbg_in_range = 1'b1;
    end else begin : g_part
      assign bus_in_range = (mem_addr < ADDR_W'(DEPTH));
      assign dbg_in_range = (dbg_addr < ADDR_W'(DEPTH));
    end
  endgenerate

`ifdef DMA_MEM_WPROT_EN
  logic wp_hit;
  // Inclusive window; an inverted window matches nothing by construction.
  assign wp_hit    = (mem_addr >= wp_lo) && (mem_addr <= wp_hi);
  assign bus_wr_ok = mem_write && bus_in_range && !wp_hit;
`else
  assign bus_wr_ok = mem_write && bus_in_range;
`endif

  // Backdoor read, zero outside the implemented array.
  always_comb begin
    dbg_rdata = '0;
    if (dbg_in_range) begin
      dbg_rdata = mem_array[IDX_W'(dbg_addr)];
    end
  end

  // Array storage is never reset; the backdoor write is last so it wins
  // over a same-address bus write at the same edge.
  always_ff @(posedge clk) begin
    if (bus_wr_ok && !rst) begin
      mem_array[IDX_W'(mem_addr)] <= mem_wdata;
    end
    if (dbg_we && dbg_in_range) begin
      mem_array[IDX_W'(dbg_addr)] <= dbg_wdata;
    end
  end

  // Read FSM, counters and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      rd_addr   <= '0;
      rd_ok     <= 1'b0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      ovr_err   <= 1'b0;
      range_err <= 1'b0;
`ifdef DMA_MEM_WPROT_EN
      wp_err    <= 1'b0;
`endif
    end else begin
      mem_ready <= 1'b0;

      if (bus_wr_ok) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
      if ((mem_write || mem_read) && !bus_in_range) begin
        range_err <= 1'b1;
      end
`ifdef DMA_MEM_WPROT_EN
      if (mem_write && bus_in_range && wp_hit) begin
        wp_err <= 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          if (mem_read) begin
            rd_addr <= mem_addr;
            rd_ok   <= bus_in_range;
            lat_cnt <= CNT_W'(READ_LAT - 1);
            busy    <= 1'b1;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_read) begin
            ovr_err <= 1'b1;
          end
          if (lat_cnt == '0) begin
            // Array read sees the pre-edge contents: a write at this edge is not returned.
            mem_rdata <= rd_ok ? mem_array[IDX_W'(rd_addr)] : '0;
            mem_ready <= 1'b1;
            rd_cnt    <= rd_cnt + 16'd1;
            state     <= RD_RESP;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        RD_RESP: begin
          // A read here is a fresh back-to-back request.
          if (mem_read) begin
            rd_addr <= mem_addr;
            rd_ok   <= bus_in_range;
            lat_cnt <= CNT_W'(READ_LAT - 1);
            state   <= RD_WAIT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Bench for dma_mem_responder: main instance (DEPTH=256) plus a DEPTH=128
// instance for range behaviour. Read responses of the main instance are
// checked against a queue of expected {data, due cycle} entries.
module tb_dma_mem_responder;

  localparam int unsigned RL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mem_addr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [7:0]  mem_wdata = '0;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        dbg_we = 1'b0;
  logic [7:0]  dbg_addr = '0;
  logic [7:0]  dbg_wdata = '0;
  logic [7:0]  dbg_rdata;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic        ovr_err;
  logic        range_err;

  logic [7:0]  s_mem_addr = '0;
  logic        s_mem_read = 1'b0;
  logic        s_mem_write = 1'b0;
  logic [7:0]  s_mem_wdata = '0;
  logic [7:0]  s_mem_rdata;
  logic        s_mem_ready;
  logic        s_busy;
  logic        s_dbg_we = 1'b0;
  logic [7:0]  s_dbg_addr = '0;
  logic [7:0]  s_dbg_wdata = '0;
  logic [7:0]  s_dbg_rdata;
  logic [15:0] s_rd_cnt;
  logic [15:0] s_wr_cnt;
  logic        s_ovr_err;
  logic        s_range_err;

`ifdef DMA_MEM_WPROT_EN
  logic [7:0]  wp_lo = 8'hFF;
  logic [7:0]  wp_hi = 8'h00;
  logic        wp_err;
  logic        s_wp_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  dma_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .rd_cnt(rd_cnt),
    .wr_cnt(wr_cnt), .ovr_err(ovr_err),
`ifdef DMA_MEM_WPROT_EN
    .wp_lo(wp_lo), .wp_hi(wp_hi), .wp_err(wp_err),
`endif
    .range_err(range_err)
  );

  dma_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .READ_LAT(RL)) dut_s (
    .clk(clk), .rst(rst), .mem_addr(s_mem_addr), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata),
    .mem_ready(s_mem_ready), .busy(s_busy), .dbg_we(s_dbg_we),
    .dbg_addr(s_dbg_addr), .dbg_wdata(s_dbg_wdata), .dbg_rdata(s_dbg_rdata),
    .rd_cnt(s_rd_cnt), .wr_cnt(s_wr_cnt), .ovr_err(s_ovr_err),
`ifdef DMA_MEM_WPROT_EN
    .wp_lo(wp_lo), .wp_hi(wp_hi), .wp_err(s_wp_err),
`endif
    .range_err(s_range_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every mem_ready pulse must match the oldest
  // expectation in data and cycle; an overdue expectation is a miss.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready got data=%h cyc=%0d exp no response", mem_rdata, cyc);
        end else begin
          e = sb.pop_front();
          if (mem_rdata !== e.data || cyc != e.due) begin
            errors++;
            $display("FAIL read_resp got data=%h cyc=%0d exp data=%h cyc=%0d", mem_rdata, cyc, e.data, e.due);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_ready got none at cyc=%0d exp data=%h cyc=%0d", cyc, sb[0].data, sb[0].due);
        e = sb.pop_front();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic [7:0] d);
    sb.push_back('{data: d, due: cyc + 1 + int'(RL)});
  endfunction

  task automatic dbg_write(input logic [7:0] a, input logic [7:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    tick();
    dbg_we = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (mem_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic s_wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (s_mem_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({mem_ready, busy, ovr_err, range_err} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {mem_ready, busy, ovr_err, range_err});
    end
    checks++;
    if ({mem_rdata, rd_cnt, wr_cnt} !== 40'h0) begin
      errors++; $display("FAIL reset_regs got=%h exp=0", {mem_rdata, rd_cnt, wr_cnt});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_range();
    bit ok;
    s_mem_addr = 8'h05; s_mem_wdata = 8'h77; s_mem_write = 1'b1; tick();
    s_mem_addr = 8'h10; s_mem_wdata = 8'h44; tick();
    s_mem_write = 1'b0;
    checks++;
    if (s_wr_cnt !== 16'd2) begin errors++; $display("FAIL rng_wr_in got=%0d exp=2", s_wr_cnt); end
    s_mem_addr = 8'h05; s_mem_read = 1'b1; tick(); s_mem_read = 1'b0;
    s_wait_ready(ok);
    checks++;
    if (!ok || s_mem_rdata !== 8'h77 || s_range_err !== 1'b0) begin
      errors++; $display("FAIL rng_rd_in got ok=%0d data=%h err=%b exp ok=1 data=77 err=0", ok, s_mem_rdata, s_range_err);
    end
    tick();
    s_mem_addr = 8'h90; s_mem_read = 1'b1; tick(); s_mem_read = 1'b0;
    s_wait_ready(ok);
    checks++;
    if (!ok || s_mem_rdata !== 8'h00 || s_range_err !== 1'b1 || s_rd_cnt !== 16'd2) begin
      errors++; $display("FAIL rng_rd_out got ok=%0d data=%h err=%b rd=%0d exp ok=1 data=00 err=1 rd=2", ok, s_mem_rdata, s_range_err, s_rd_cnt);
    end
    tick();
    s_mem_addr = 8'h90; s_mem_wdata = 8'h99; s_mem_write = 1'b1; tick(); s_mem_write = 1'b0;
    checks++;
    if (s_wr_cnt !== 16'd2) begin errors++; $display("FAIL rng_wr_out got=%0d exp=2", s_wr_cnt); end
    s_dbg_addr = 8'h10; #1;
    checks++;
    if (s_dbg_rdata !== 8'h44) begin errors++; $display("FAIL rng_alias got=%h exp=44", s_dbg_rdata); end
    s_dbg_addr = 8'h90; #1;
    checks++;
    if (s_dbg_rdata !== 8'h00) begin errors++; $display("FAIL rng_dbg_out got=%h exp=00", s_dbg_rdata); end
    checks++;
    if (s_busy !== 1'b0 || s_ovr_err !== 1'b0) begin
      errors++; $display("FAIL rng_idle got busy=%b ovr=%b exp 0 0", s_busy, s_ovr_err);
    end
  endtask

  task automatic test_single_read();
    logic [15:0] rb;
    rb = rd_cnt;
    dbg_write(8'h10, 8'hA5);
    checks++;
    if (dbg_rdata !== 8'hA5) begin errors++; $display("FAIL sr_dbg got=%h exp=a5", dbg_rdata); end
    mem_addr = 8'h10; mem_read = 1'b1; push(8'hA5); tick(); mem_read = 1'b0;
    checks++;
    if ({busy, mem_ready} !== 2'b10) begin errors++; $display("FAIL sr_accept got=%b exp=10", {busy, mem_ready}); end
    tick();
    checks++;
    if ({busy, mem_ready} !== 2'b10) begin errors++; $display("FAIL sr_wait got=%b exp=10", {busy, mem_ready}); end
    tick();
    checks++;
    if ({busy, mem_ready} !== 2'b11) begin errors++; $display("FAIL sr_ready got=%b exp=11", {busy, mem_ready}); end
    tick();
    checks++;
    if ({busy, mem_ready} !== 2'b00 || mem_rdata !== 8'hA5) begin
      errors++; $display("FAIL sr_done got=%b data=%h exp=00 data=a5", {busy, mem_ready}, mem_rdata);
    end
    checks++;
    if (rd_cnt !== rb + 16'd1) begin errors++; $display("FAIL sr_rdcnt got=%0d exp=%0d", rd_cnt, rb + 16'd1); end
  endtask

  task automatic test_copy();
    logic [7:0]  src_v [3];
    logic [15:0] rb, wb;
    logic [7:0]  d;
    bit ok;
    src_v = '{8'h11, 8'h22, 8'h33};
    rb = rd_cnt; wb = wr_cnt;
    for (int i = 0; i < 3; i++) dbg_write(8'(i), src_v[i]);
    for (int i = 0; i < 3; i++) begin
      mem_addr = 8'(i); mem_read = 1'b1; push(src_v[i]); tick(); mem_read = 1'b0;
      wait_ready(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL copy_timeout got none exp ready idx=%0d", i); end
      d = mem_rdata;
      mem_addr = 8'h80 + 8'(i); mem_wdata = d; mem_write = 1'b1; tick(); mem_write = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      dbg_addr = 8'h80 + 8'(i); #1;
      checks++;
      if (dbg_rdata !== src_v[i]) begin errors++; $display("FAIL copy_dst got=%h exp=%h idx=%0d", dbg_rdata, src_v[i], i); end
    end
    checks++;
    if (wr_cnt !== wb + 16'd3 || rd_cnt !== rb + 16'd3) begin
      errors++; $display("FAIL copy_cnt got wr=%0d rd=%0d exp wr=%0d rd=%0d", wr_cnt, rd_cnt, wb + 16'd3, rb + 16'd3);
    end
  endtask

  task automatic test_rw_order();
    logic [15:0] wb;
    wb = wr_cnt;
    dbg_write(8'h20, 8'h5A);
    // Write at the capture edge: old data returned.
    mem_addr = 8'h20; mem_read = 1'b1; push(8'h5A); tick(); mem_read = 1'b0;
    tick();
    mem_wdata = 8'hC3; mem_write = 1'b1; tick(); mem_write = 1'b0;
    tick();
    dbg_addr = 8'h20; #1;
    checks++;
    if (dbg_rdata !== 8'hC3) begin errors++; $display("FAIL rw_late_wr got=%h exp=c3", dbg_rdata); end
    // Write one edge before capture: new data returned.
    mem_read = 1'b1; push(8'hE7); tick(); mem_read = 1'b0;
    mem_wdata = 8'hE7; mem_write = 1'b1; tick(); mem_write = 1'b0;
    tick(); tick();
    // Read and write together from IDLE.
    dbg_write(8'h30, 8'h01);
    mem_addr = 8'h30; mem_wdata = 8'h3C; mem_read = 1'b1; mem_write = 1'b1; push(8'h3C);
    tick(); mem_read = 1'b0; mem_write = 1'b0;
    tick(); tick(); tick();
    // Backdoor beats bus on the same address, bus still counted.
    mem_addr = 8'h31; mem_wdata = 8'hAA; mem_write = 1'b1;
    dbg_we = 1'b1; dbg_addr = 8'h31; dbg_wdata = 8'hBB;
    tick(); mem_write = 1'b0; dbg_we = 1'b0;
    checks++;
    if (dbg_rdata !== 8'hBB) begin errors++; $display("FAIL rw_dbg_wins got=%h exp=bb", dbg_rdata); end
    checks++;
    if (wr_cnt !== wb + 16'd4) begin errors++; $display("FAIL rw_wrcnt got=%0d exp=%0d", wr_cnt, wb + 16'd4); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rb;
    bit ok;
    rb = rd_cnt;
    mem_addr = 8'h00; mem_read = 1'b1; push(8'h11); tick(); mem_read = 1'b0;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_first got none exp ready"); end
    mem_addr = 8'h01; mem_read = 1'b1; push(8'h22); tick(); mem_read = 1'b0;
    checks++;
    if ({busy, mem_ready} !== 2'b10) begin errors++; $display("FAIL b2b_rearm got=%b exp=10", {busy, mem_ready}); end
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_second got none exp ready"); end
    tick();
    checks++;
    if (busy !== 1'b0 || rd_cnt !== rb + 16'd2 || ovr_err !== 1'b0) begin
      errors++; $display("FAIL b2b_end got busy=%b rd=%0d ovr=%b exp busy=0 rd=%0d ovr=0", busy, rd_cnt, ovr_err, rb + 16'd2);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] rb;
    rb = rd_cnt;
    mem_addr = 8'h01; mem_read = 1'b1; push(8'h22); tick();
    mem_addr = 8'h02; tick(); mem_read = 1'b0;
    repeat (5) tick();
    checks++;
    if (ovr_err !== 1'b1 || rd_cnt !== rb + 16'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL ovr got ovr=%b rd=%0d busy=%b exp ovr=1 rd=%0d busy=0", ovr_err, rd_cnt, busy, rb + 16'd1);
    end
  endtask

`ifdef DMA_MEM_WPROT_EN
  task automatic test_wprot();
    logic [15:0] wb;
    wp_lo = 8'h40; wp_hi = 8'h4F;
    dbg_write(8'h45, 8'h12);
    wb = wr_cnt;
    mem_addr = 8'h45; mem_wdata = 8'h55; mem_write = 1'b1; tick(); mem_write = 1'b0;
    dbg_addr = 8'h45; #1;
    checks++;
    if (dbg_rdata !== 8'h12 || wp_err !== 1'b1 || wr_cnt !== wb) begin
      errors++; $display("FAIL wp_block got data=%h err=%b wr=%0d exp data=12 err=1 wr=%0d", dbg_rdata, wp_err, wr_cnt, wb);
    end
    mem_addr = 8'h50; mem_wdata = 8'h66; mem_write = 1'b1; tick(); mem_write = 1'b0;
    dbg_addr = 8'h50; #1;
    checks++;
    if (dbg_rdata !== 8'h66 || wr_cnt !== wb + 16'd1) begin
      errors++; $display("FAIL wp_pass got data=%h wr=%0d exp data=66 wr=%0d", dbg_rdata, wr_cnt, wb + 16'd1);
    end
    wp_lo = 8'hFF; wp_hi = 8'h00;
  endtask
`endif

  task automatic test_reset_mid_read();
    mem_addr = 8'h10; mem_read = 1'b1; tick(); mem_read = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_ready, busy, ovr_err, range_err} !== 4'b0 || {mem_rdata, rd_cnt, wr_cnt} !== 40'h0) begin
      errors++; $display("FAIL rst_mid got flags=%b regs=%h exp 0", {mem_ready, busy, ovr_err, range_err}, {mem_rdata, rd_cnt, wr_cnt});
    end
    tick();
    rst = 1'b0;
    repeat (6) tick();
    checks++;
    if (busy !== 1'b0 || rd_cnt !== 16'd0 || mem_rdata !== 8'h00) begin
      errors++; $display("FAIL rst_abort got busy=%b rd=%0d data=%h exp 0 0 00", busy, rd_cnt, mem_rdata);
    end
    dbg_addr = 8'h10; #1;
    checks++;
    if (dbg_rdata !== 8'hA5) begin errors++; $display("FAIL rst_keep got=%h exp=a5", dbg_rdata); end
    dbg_addr = 8'h80; #1;
    checks++;
    if (dbg_rdata !== 8'h11) begin errors++; $display("FAIL rst_keep2 got=%h exp=11", dbg_rdata); end
  endtask

  initial begin
    test_reset();
    test_range();
    test_single_read();
    test_copy();
    test_rw_order();
    test_back_to_back();
    test_overrun();
`ifdef DMA_MEM_WPROT_EN
    test_wprot();
`endif
    test_reset_mid_read();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
